shift_engine: RTL and testbench

SHIFT_ENGINE -- requirements
Module: shift_engine

---
 rtl/shift_engine_pkg.sv | 21 ++
 rtl/shift_engine_step.sv | 48 ++++
 rtl/shift_engine.sv | 126 ++++++++++++
 tb/tb_shift_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_engine_pkg.sv
// ---------------------------------------------------------------------------
// shift_engine_pkg
// Shared types for the shift engine: the two-bit operation encoding and the
// control FSM state encoding. Imported by shift_step and shift_engine.
// ---------------------------------------------------------------------------
package shift_engine_pkg;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_engine_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Purely combinational single-position shifter used once per SHIFT cycle.
//   op        : operation (LSL, LSR, ASR, ROR)
//   data      : current data register value
//   result    : data shifted by one position
//   shift_out : the bit pushed out of the word by this step
// ---------------------------------------------------------------------------
module shift_step
    import shift_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  op_t                   op,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  shift_out
);

    // One-bit shift; rotate feeds the outgoing LSB back into the MSB.
    always_comb begin
        result    = data;
        shift_out = 1'b0;
        case (op)
            OP_LSL: begin
                result    = {data[DATA_WIDTH-2:0], 1'b0};
                shift_out = data[DATA_WIDTH-1];
            end
            OP_LSR: begin
                result    = {1'b0, data[DATA_WIDTH-1:1]};
                shift_out = data[0];
            end
            OP_ASR: begin
                result    = {data[DATA_WIDTH-1], data[DATA_WIDTH-1:1]};
                shift_out = data[0];
            end
            OP_ROR: begin
                result    = {data[0], data[DATA_WIDTH-1:1]};
                shift_out = data[0];
            end
            default: begin
                result    = data;
                shift_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// ---------------------------------------------------------------------------
// shift_engine
// Multi-cycle shifter: a data register shifted one bit per clock for a
// latched number of positions, with an IDLE/SHIFT/DONE control FSM.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   load   : capture din into the data register (IDLE only, wins over start)
//   din    : load data
//   start  : begin an operation (IDLE only)
//   op     : 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   amount : number of bit positions
//   dout   : data register
//   carry  : last bit shifted out
//   zero   : dout == 0
//   busy   : operation in progress
//   done   : one-cycle completion pulse
// Build option: define SHIFT_ENGINE_ROTATE_EN to enable ROR. Without it,
// op 11 completes immediately and leaves dout/carry untouched.
// ---------------------------------------------------------------------------
module shift_engine
    import shift_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [AMT_WIDTH-1:0]  amount,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  carry,
    output logic                  zero,
    output logic                  busy,
    output logic                  done
);

    state_t                 state;
    state_t                 state_next;
    op_t                    op_q;
    logic [AMT_WIDTH-1:0]   count;
    logic [DATA_WIDTH-1:0]  step_result;
    logic                   step_out;
    logic                   skip_shift;

    // Operations that finish without any shift cycles besides amount == 0.
`ifdef SHIFT_ENGINE_ROTATE_EN
    assign skip_shift = 1'b0;
`else
    assign skip_shift = (op_t'(op) == OP_ROR);
`endif

    shift_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .op        (op_q),
        .data      (dout),
        .result    (step_result),
        .shift_out (step_out)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the last SHIFT cycle is the one that sees count == 1.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!load && start) begin
                    if ((amount == '0) || skip_shift) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (count == AMT_WIDTH'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: load/latch only in IDLE, one shift step per SHIFT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout  <= '0;
            carry <= 1'b0;
            count <= '0;
            op_q  <= OP_LSL;
        end else if (state == ST_IDLE) begin
            if (load) begin
                dout  <= din;
                carry <= 1'b0;
            end else if (start) begin
                op_q  <= op_t'(op);
                count <= amount;
            end
        end else if (state == ST_SHIFT) begin
            dout  <= step_result;
            carry <= step_out;
            count <= count - AMT_WIDTH'(1);
        end
    end

    assign zero = (dout == '0);
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_engine.sv
// ---------------------------------------------------------------------------
// tb_shift_engine
// Self-checking bench for shift_engine with DATA_WIDTH = 8. Expected values
// come from an arithmetic reference model of the shift operations.
// Define SHIFT_ENGINE_ROTATE_EN for both bench and RTL to test the ROR build.
// ---------------------------------------------------------------------------
module tb_shift_engine;

    localparam int W = 8;
    localparam int A = 3;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] din;
    logic         start;
    logic [1:0]   op;
    logic [A-1:0] amount;
    logic [W-1:0] dout;
    logic         carry;
    logic         zero;
    logic         busy;
    logic         done;

    int           total;
    int           bad;
    logic [W-1:0] model_dout;
    logic         model_carry;

    shift_engine #(
        .DATA_WIDTH (W),
        .AMT_WIDTH  (A)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .din    (din),
        .start  (start),
        .op     (op),
        .amount (amount),
        .dout   (dout),
        .carry  (carry),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: shifting by n positions at once, returns {carry, data}.
    function automatic logic [W:0] ref_shift(input logic [W-1:0] v, input logic c,
                                             input int o, input int n);
        int vi;
        int si;
        int r;
        int cr;
        vi = int'(v);
        r  = vi;
        cr = c ? 1 : 0;
        if (n != 0) begin
            case (o)
                0: begin
                    r  = (vi << n) & 255;
                    cr = (vi >> (W - n)) & 1;
                end
                1: begin
                    r  = vi >> n;
                    cr = (vi >> (n - 1)) & 1;
                end
                2: begin
                    si = (vi >= 128) ? vi - 256 : vi;
                    r  = (si >>> n) & 255;
                    cr = (vi >> (n - 1)) & 1;
                end
                default: begin
`ifdef SHIFT_ENGINE_ROTATE_EN
                    r  = ((vi >> n) | (vi << (W - n))) & 255;
                    cr = (vi >> (n - 1)) & 1;
`endif
                end
            endcase
        end
        return {cr[0], r[7:0]};
    endfunction

    // Number of clock edges after the start edge until done is seen.
    function automatic int ref_latency(input int o, input int n);
`ifdef SHIFT_ENGINE_ROTATE_EN
        return n;
`else
        return (o == 3) ? 0 : n;
`endif
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [W-1:0] value);
        din  = value;
        load = 1'b1;
        @(posedge clk);
        #1;
        load        = 1'b0;
        model_dout  = value;
        model_carry = 1'b0;
        check_output("load_dout", 32'(dout), 32'(value));
        check_output("load_carry", 32'(carry), 32'd0);
    endtask

    // Start one operation, optionally hammer load/start/op/amount while busy,
    // then compare latency, busy length and result against the model.
    task automatic run_op(input int o, input int n, input bit interfere);
        logic [W:0] exp;
        int         k_exp;
        int         edges;
        int         busy_cnt;
        bit         seen;
        exp      = ref_shift(model_dout, model_carry, o, n);
        k_exp    = ref_latency(o, n);
        op       = 2'(o);
        amount   = A'(n);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        edges    = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (interfere) begin
                load   = 1'b1;
                start  = 1'b1;
                din    = W'($urandom);
                op     = 2'($urandom);
                amount = A'($urandom);
            end
            @(posedge clk);
            #1;
            edges++;
        end
        load  = 1'b0;
        start = 1'b0;
        check_output("done_seen", 32'(seen), 32'd1);
        check_output("done_latency", 32'(edges), 32'(k_exp));
        check_output("busy_cycles", 32'(busy_cnt), 32'(k_exp + 1));
        check_output("op_dout", 32'(dout), 32'(exp[W-1:0]));
        check_output("op_carry", 32'(carry), 32'(exp[W]));
        check_output("op_zero", 32'(zero), 32'(exp[W-1:0] == '0));
        @(posedge clk);
        #1;
        check_output("done_pulse_end", 32'(done), 32'd0);
        check_output("busy_end", 32'(busy), 32'd0);
        model_dout  = exp[W-1:0];
        model_carry = exp[W];
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        load        = 1'b0;
        start       = 1'b0;
        din         = '0;
        op          = 2'b00;
        amount      = '0;
        model_dout  = '0;
        model_carry = 1'b0;

        // Power-on reset state.
        #2;
        check_output("rst_dout", 32'(dout), 32'd0);
        check_output("rst_carry", 32'(carry), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_zero", 32'(zero), 32'd1);
        #10;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases.
        apply_stimulus(8'h96);
        run_op(0, 3, 1'b0);
        check_output("lsl3_dout", 32'(dout), 32'h0000_00B0);
        check_output("lsl3_carry", 32'(carry), 32'd0);

        apply_stimulus(8'h96);
        run_op(2, 2, 1'b0);
        check_output("asr2_dout", 32'(dout), 32'h0000_00E5);
        check_output("asr2_carry", 32'(carry), 32'd1);

        apply_stimulus(8'h81);
        run_op(3, 1, 1'b0);
`ifdef SHIFT_ENGINE_ROTATE_EN
        check_output("ror1_dout", 32'(dout), 32'h0000_00C0);
        check_output("ror1_carry", 32'(carry), 32'd1);
`else
        check_output("ror1_dout", 32'(dout), 32'h0000_0081);
        check_output("ror1_carry", 32'(carry), 32'd0);
`endif

        apply_stimulus(8'h5A);
        run_op(0, 0, 1'b0);
        check_output("amt0_dout", 32'(dout), 32'h0000_005A);

        apply_stimulus(8'hFF);
        run_op(1, 5, 1'b1);
        check_output("lsr5_dout", 32'(dout), 32'h0000_0007);

        // load and start together in IDLE: load wins, no operation.
        din    = 8'h3C;
        load   = 1'b1;
        start  = 1'b1;
        op     = 2'b00;
        amount = 3'd3;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        model_dout  = 8'h3C;
        model_carry = 1'b0;
        check_output("ls_same_dout", 32'(dout), 32'h0000_003C);
        check_output("ls_same_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_output("ls_same_busy2", 32'(busy), 32'd0);
        check_output("ls_same_done", 32'(done), 32'd0);
        check_output("ls_same_dout2", 32'(dout), 32'h0000_003C);

        // Randomized operations, chained and with interference.
        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(0, 2) == 0) apply_stimulus(W'($urandom));
            run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                   bit'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a long operation.
        apply_stimulus(8'hA5);
        op     = 2'b00;
        amount = 3'd7;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        #2;
        reset = 1'b0;
        #1;
        check_output("mid_rst_dout", 32'(dout), 32'd0);
        check_output("mid_rst_carry", 32'(carry), 32'd0);
        check_output("mid_rst_busy", 32'(busy), 32'd0);
        check_output("mid_rst_done", 32'(done), 32'd0);
        check_output("mid_rst_zero", 32'(zero), 32'd1);
        @(posedge clk);
        #1;
        check_output("held_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        din   = 8'hC3;
        load  = 1'b1;
        @(posedge clk);
        #1;
        load        = 1'b0;
        model_dout  = 8'hC3;
        model_carry = 1'b0;
        check_output("post_rst_load", 32'(dout), 32'h0000_00C3);
        check_output("post_rst_done", 32'(done), 32'd0);
        run_op(2, 4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
